vfd_scanout: RTL and testbench



---
 rtl/vfd_scanout.sv | 186 ++++++++++++++++++
 tb/tb_vfd_scanout.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vfd_scanout.sv
// vfd_scanout: 640x480@60 VGA scanout of an RGB332 framebuffer held in VRAM.
// Two pixel-enable stages: stage 0 issues the VRAM read and latches the
// timing flags, stage 1 captures the read data and expands it to 24-bit RGB.
// Optional feature macro: VFD_SCANOUT_SCANLINE_EN (halves intensity of odd lines).
module vfd_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pix,
   output logic [18:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hs,
   output logic        vs,
   output logic        hblank,
   output logic        vblank,
   output logic        de
);

   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + 16);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + 112);
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + 159);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + 10);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + 12);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + 44);

   // Replicate a 3-bit channel into 8 bits so full scale maps to 0xFF.
   function automatic logic [7:0] expand3(input logic [2:0] v);
      return {v, v, v[2:1]};
   endfunction

   // Replicate a 2-bit channel into 8 bits.
   function automatic logic [7:0] expand2(input logic [1:0] v);
      return {v, v, v, v};
   endfunction

`ifdef VFD_SCANOUT_SCANLINE_EN
   // 50% dim for scanline emulation.
   function automatic logic [7:0] dim(input logic [7:0] v);
      return {1'b0, v[7:1]};
   endfunction
`endif

   logic [9:0]  r_hc;
   logic [9:0]  r_vc;
   logic [18:0] r_addr;
   logic [18:0] r_vram_addr;

   logic        w_active;
   logic        w_line_end;
   logic        w_frame_end;

   logic        r_vld_p0;
   logic        r_hs_p0;
   logic        r_vs_p0;
   logic        r_hb_p0;
   logic        r_vb_p0;
`ifdef VFD_SCANOUT_SCANLINE_EN
   logic        r_odd_p0;
`endif

   logic [7:0]  w_red;
   logic [7:0]  w_grn;
   logic [7:0]  w_blu;

   logic        r_vld_p1;
   logic        r_hs_p1;
   logic        r_vs_p1;
   logic        r_hb_p1;
   logic        r_vb_p1;
   logic [7:0]  r_red_p1;
   logic [7:0]  r_grn_p1;
   logic [7:0]  r_blu_p1;

   assign w_active    = (r_hc < H_ACT) && (r_vc < V_ACT);
   assign w_line_end  = (r_hc == H_LAST);
   assign w_frame_end = w_line_end && (r_vc == V_LAST);

   // Raster position counters, stepping once per pixel enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (ce_pix) begin
         if (w_line_end) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
         end else begin
            r_hc <= r_hc + 10'd1;
         end
      end
   end

   // Linear VRAM address; the read address only moves on visible pixels so it
   // never points past the last pixel during blanking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr      <= '0;
         r_vram_addr <= '0;
      end else if (ce_pix) begin
         if (w_frame_end) begin
            r_addr <= '0;
         end else if (w_active) begin
            r_vram_addr <= r_addr;
            r_addr      <= r_addr + 19'd1;
         end
      end
   end

   // Stage 0: timing flags for the pixel whose read was just issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p0 <= 1'b0;
         r_hs_p0  <= 1'b1;
         r_vs_p0  <= 1'b1;
         r_hb_p0  <= 1'b1;
         r_vb_p0  <= 1'b1;
`ifdef VFD_SCANOUT_SCANLINE_EN
         r_odd_p0 <= 1'b0;
`endif
      end else if (ce_pix) begin
         r_vld_p0 <= w_active;
         r_hs_p0  <= !((r_hc >= H_SYNC_BEG) && (r_hc < H_SYNC_END));
         r_vs_p0  <= !((r_vc >= V_SYNC_BEG) && (r_vc < V_SYNC_END));
         r_hb_p0  <= (r_hc >= H_ACT);
         r_vb_p0  <= (r_vc >= V_ACT);
`ifdef VFD_SCANOUT_SCANLINE_EN
         r_odd_p0 <= r_vc[0];
`endif
      end
   end

   // RGB332 to RGB888 expansion of the returned VRAM byte.
   always_comb begin
      w_red = expand3(vram_data[7:5]);
      w_grn = expand3(vram_data[4:2]);
      w_blu = expand2(vram_data[1:0]);
`ifdef VFD_SCANOUT_SCANLINE_EN
      if (r_odd_p0) begin
         w_red = dim(w_red);
         w_grn = dim(w_grn);
         w_blu = dim(w_blu);
      end
`endif
   end

   // Stage 1: capture colour and realign sync/blank with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p1 <= 1'b0;
         r_hs_p1  <= 1'b1;
         r_vs_p1  <= 1'b1;
         r_hb_p1  <= 1'b1;
         r_vb_p1  <= 1'b1;
         r_red_p1 <= '0;
         r_grn_p1 <= '0;
         r_blu_p1 <= '0;
      end else if (ce_pix) begin
         r_vld_p1 <= r_vld_p0;
         r_hs_p1  <= r_hs_p0;
         r_vs_p1  <= r_vs_p0;
         r_hb_p1  <= r_hb_p0;
         r_vb_p1  <= r_vb_p0;
         r_red_p1 <= r_vld_p0 ? w_red : 8'd0;
         r_grn_p1 <= r_vld_p0 ? w_grn : 8'd0;
         r_blu_p1 <= r_vld_p0 ? w_blu : 8'd0;
      end
   end

   assign vram_addr = r_vram_addr;
   assign r         = r_red_p1;
   assign g         = r_grn_p1;
   assign b         = r_blu_p1;
   assign hs        = r_hs_p1;
   assign vs        = r_vs_p1;
   assign hblank    = r_hb_p1;
   assign vblank    = r_vb_p1;
   assign de        = r_vld_p1;

endmodule

// File: tb/tb_vfd_scanout.sv
// Testbench for vfd_scanout, run with a reduced active area so whole frames
// fit in a short simulation; porch and sync widths are the real VGA ones.
module tb_vfd_scanout;

   localparam int H     = 32;
   localparam int V     = 6;
   localparam int HT    = H + 160;
   localparam int VT    = V + 45;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce_pix = 1'b0;
   logic [18:0] vram_addr;
   logic [7:0]  vram_data = 8'd0;
   logic [7:0]  r, g, b;
   logic        hs, vs, hblank, vblank, de;

   vfd_scanout #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .vram_addr(vram_addr), .vram_data(vram_data),
      .r(r), .g(g), .b(b),
      .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // VRAM content: 0 -> low address byte, 1 -> all 0xFF, 2 -> scrambled.
   int          mode = 0;
   logic [7:0]  mask = 8'd0;

   function automatic logic [7:0] vram_fn(input int a);
      if (mode == 1) return 8'hFF;
      if (mode == 2) return 8'((a * 37 + int'(mask)) & 255);
      return 8'(a & 255);
   endfunction

   // Synchronous-read VRAM, one clock of latency.
   always @(posedge clk) vram_data <= vram_fn(int'(vram_addr));

   // Reference colour: channel value scaled to 0..255 with rounding.
   function automatic void expand(input logic [7:0] d, input int y,
                                  output int er, output int eg, output int eb);
      int dv;
      dv = int'(d);
      er = ((dv / 32) * 255 + 3) / 7;
      eg = (((dv / 4) % 8) * 255 + 3) / 7;
      eb = (dv % 4) * 85;
`ifdef VFD_SCANOUT_SCANLINE_EN
      if (y % 2 == 1) begin
         er = er / 2;
         eg = eg / 2;
         eb = eb / 2;
      end
`else
      if (y < 0) er = 0;
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs
   int e_r, e_g, e_b, e_hs, e_vs, e_hb, e_vb, e_de, e_addr;
   int n = 0;
   bit started = 1'b0;
   bit count_en = 1'b0;
   int hs_low = 0, vs_low = 0;
   logic ce_s, rs_s;

   task automatic set_reset_exp();
      e_r = 0; e_g = 0; e_b = 0;
      e_hs = 1; e_vs = 1; e_hb = 1; e_vb = 1; e_de = 0; e_addr = 0;
   endtask

   // Compare process: model advances on each accepted pixel enable.
   initial begin
      int s, sx, sy, o, ox, oy;
      bit act;
      set_reset_exp();
      forever begin
         @(posedge clk);
         ce_s = ce_pix;
         rs_s = reset;
         #2;
         if (rs_s) begin
            started = 1'b1;
            n = 0;
            set_reset_exp();
         end else if (ce_s && started) begin
            n++;
            s  = (n - 1) % FRAME;
            sx = s % HT;
            sy = s / HT;
            if (sx < H && sy < V) e_addr = sy * H + sx;
            if (n >= 2) begin
               o   = (n - 2) % FRAME;
               ox  = o % HT;
               oy  = o / HT;
               act = (ox < H) && (oy < V);
               e_hs = (ox >= H + 16 && ox < H + 112) ? 0 : 1;
               e_vs = (oy >= V + 10 && oy < V + 12) ? 0 : 1;
               e_hb = (ox >= H) ? 1 : 0;
               e_vb = (oy >= V) ? 1 : 0;
               e_de = act ? 1 : 0;
               if (act) expand(vram_fn(oy * H + ox), oy, e_r, e_g, e_b);
               else begin e_r = 0; e_g = 0; e_b = 0; end
            end
            if (mode == 0) begin
               if (n == 6)  chk("addr_px5", int'(vram_addr), 5);
               if (n == 7) begin
                  chk("px5_r", int'(r), 8'h00);
                  chk("px5_g", int'(g), 8'h24);
                  chk("px5_b", int'(b), 8'h55);
                  chk("px5_de", int'(de), 1);
               end
               if (n == (V - 1) * HT + H) chk("addr_last", int'(vram_addr), H * V - 1);
               if (n == FRAME + 1)        chk("addr_wrap", int'(vram_addr), 0);
            end
            if (count_en && n >= 2 && n <= FRAME + 1) begin
               if (!hs) hs_low++;
               if (!vs) vs_low++;
               if (n == FRAME + 1) begin
                  chk("hs_low_frame", hs_low, 96 * VT);
                  chk("vs_low_frame", vs_low, 2 * HT);
                  count_en = 1'b0;
               end
            end
         end
         if (started) begin
            chk("r", int'(r), e_r);
            chk("g", int'(g), e_g);
            chk("b", int'(b), e_b);
            chk("hs", int'(hs), e_hs);
            chk("vs", int'(vs), e_vs);
            chk("hblank", int'(hblank), e_hb);
            chk("vblank", int'(vblank), e_vb);
            chk("de", int'(de), e_de);
            chk("vram_addr", int'(vram_addr), e_addr);
         end
      end
   end

   // Pixel enables with random spacing, never closer than 2 clocks.
   task automatic pulses(input int cnt);
      int gap;
      for (int i = 0; i < cnt; i++) begin
         ce_pix = 1'b1;
         @(posedge clk); #1;
         ce_pix = 1'b0;
         gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 4)) : 1;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   // Reset held for a few cycles with ce_pix high to show reset dominates.
   task automatic do_reset(input int new_mode);
      reset  = 1'b1;
      ce_pix = 1'b1;
      mode   = new_mode;
      mask   = 8'($urandom_range(0, 255));
      repeat (3) begin @(posedge clk); #1; end
      reset  = 1'b0;
      ce_pix = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pr, pg, pb;
      expand(8'h05, 0, pr, pg, pb);
      chk("model_05_r", pr, 8'h00);
      chk("model_05_g", pg, 8'h24);
      chk("model_05_b", pb, 8'h55);
`ifdef VFD_SCANOUT_SCANLINE_EN
      expand(8'hFF, 1, pr, pg, pb);
      chk("model_ff_odd", pr, 8'h7F);
      chk("model_ff_odd_b", pb, 8'h7F);
`else
      expand(8'hFF, 1, pr, pg, pb);
      chk("model_ff_odd", pr, 8'hFF);
      chk("model_ff_odd_b", pb, 8'hFF);
`endif
      expand(8'hFF, 0, pr, pg, pb);
      chk("model_ff_even", pg, 8'hFF);

      @(posedge clk); #1;
      do_reset(0);
      count_en = 1'b1;
      pulses(FRAME + 300);
      // Advance to hc=100, vc=3 and reset mid-frame.
      pulses(3 * HT + 100 - 300);
      do_reset(2);
      pulses(5000);
      // Saturated VRAM data across active lines and into vertical blanking.
      do_reset(1);
      pulses(20 * HT);
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
